// File: rtl/dragon_pkg.sv
// Shared types and widths for the dragon body logic: state encoding, length and
// pending-request counter widths, and the saturating request-counter update.
package dragon_pkg;

   localparam int unsigned MAX_LEN = 7;
   localparam int unsigned LEN_W   = 3;
   localparam int unsigned PEND_W  = 2;
   localparam int unsigned MC_W    = 6;
   localparam int unsigned CD_W    = 8;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_COOLDOWN = 2'd1,
      ST_DEAD     = 2'd2
   } state_t;

   // Request and consume in the same cycle cancel out; requests saturate at all-ones.
   function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                   input logic              inc,
                                                   input logic              dec);
      logic [PEND_W-1:0] r;
      r = p;
      if (inc && !dec && (p != '1))
         r = p + PEND_W'(1);
      else if (dec && !inc)
         r = p - PEND_W'(1);
      return r;
   endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Rising-edge detector on the raw vsync level; frame_tick is high for one cycle per frame.
module vsync_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   output logic frame_tick
);

   logic vsync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         vsync_q <= 1'b0;
      else
         vsync_q <= vsync;
   end

   assign frame_tick = vsync & ~vsync_q;

endmodule

// File: rtl/dragon_segment_scheduler.sv
// Paces dragon body steps from frame ticks and resolves queued grow/shrink requests,
// one action per step, with post-hit cooldown and a DEAD state left via restart.
module dragon_segment_scheduler
   import dragon_pkg::*;
#(
   parameter int unsigned MOVE_PERIOD     = 10,
   parameter int unsigned COOLDOWN_FRAMES = 60,
   parameter int unsigned MAX_LEN         = dragon_pkg::MAX_LEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            vsync,
   input  logic            heal_req,
   input  logic            hit_req,
   input  logic            restart,
   output logic [MC_W-1:0]  movementCounter,
   output logic            move_tick,
   output logic            heal,
   output logic            hit,
   output logic            body_clear,
   output logic [LEN_W-1:0] length,
   output logic            invuln,
   output logic            dead
);

   state_t              st_q, st_d;
   logic [MC_W-1:0]     mc_q, mc_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [PEND_W-1:0]   heal_pend_q, heal_pend_d;
   logic [PEND_W-1:0]   hit_pend_q, hit_pend_d;
   logic [CD_W-1:0]     cd_q, cd_d;
   logic                move_tick_q, move_tick_d;
   logic                heal_q, heal_d;
   logic                hit_q, hit_d;
   logic                clr_q, clr_d;
   logic                frame_tick;
   logic                step, heal_dec, hit_dec, kill;

   vsync_edge_detect u_edge (
      .clk        (clk),
      .reset      (reset),
      .vsync      (vsync),
      .frame_tick (frame_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= ST_RUN;
         mc_q        <= '0;
         len_q       <= LEN_W'(1);
         heal_pend_q <= '0;
         hit_pend_q  <= '0;
         cd_q        <= '0;
         move_tick_q <= 1'b0;
         heal_q      <= 1'b0;
         hit_q       <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         st_q        <= st_d;
         mc_q        <= mc_d;
         len_q       <= len_d;
         heal_pend_q <= heal_pend_d;
         hit_pend_q  <= hit_pend_d;
         cd_q        <= cd_d;
         move_tick_q <= move_tick_d;
         heal_q      <= heal_d;
         hit_q       <= hit_d;
         clr_q       <= clr_d;
      end
   end

   always_comb begin
      st_d        = st_q;
      mc_d        = mc_q;
      len_d       = len_q;
      cd_d        = cd_q;
      heal_pend_d = heal_pend_q;
      hit_pend_d  = hit_pend_q;
      move_tick_d = 1'b0;
      heal_d      = 1'b0;
      hit_d       = 1'b0;
      clr_d       = 1'b0;
      step        = 1'b0;
      heal_dec    = 1'b0;
      hit_dec     = 1'b0;
      kill        = 1'b0;

      if (st_q == ST_DEAD) begin
         if (restart) begin
            st_d        = ST_RUN;
            len_d       = LEN_W'(1);
            mc_d        = '0;
            cd_d        = '0;
            heal_pend_d = '0;
            hit_pend_d  = '0;
            clr_d       = 1'b1;
         end
      end else begin
         if (frame_tick) begin
            if (mc_q == MC_W'(MOVE_PERIOD)) begin
               mc_d = '0;
               step = 1'b1;
            end else begin
               mc_d = mc_q + MC_W'(1);
            end
            if (st_q == ST_COOLDOWN) begin
               cd_d = cd_q - CD_W'(1);
               if (cd_q == CD_W'(1))
                  st_d = ST_RUN;
            end
         end

         // A hit resolved on a step overrides the cooldown bookkeeping above.
         if (step) begin
            move_tick_d = 1'b1;
            if ((heal_pend_q != '0) && (hit_pend_q != '0)) begin
               heal_dec = 1'b1;
               hit_dec  = 1'b1;
            end else if (hit_pend_q != '0) begin
               if (len_q > LEN_W'(1)) begin
                  hit_d   = 1'b1;
                  len_d   = len_q - LEN_W'(1);
                  hit_dec = 1'b1;
                  cd_d    = CD_W'(COOLDOWN_FRAMES);
                  st_d    = ST_COOLDOWN;
               end else begin
                  kill = 1'b1;
                  st_d = ST_DEAD;
               end
            end else if (heal_pend_q != '0) begin
               heal_dec = 1'b1;
               if (len_q < LEN_W'(MAX_LEN)) begin
                  heal_d = 1'b1;
                  len_d  = len_q + LEN_W'(1);
               end
            end
         end

         heal_pend_d = pend_next(heal_pend_q, heal_req, heal_dec);
         hit_pend_d  = pend_next(hit_pend_q, hit_req && (st_q == ST_RUN), hit_dec);
         if (kill) begin
            heal_pend_d = '0;
            hit_pend_d  = '0;
            cd_d        = '0;
         end
      end
   end

   assign movementCounter = mc_q;
   assign move_tick       = move_tick_q;
   assign heal            = heal_q;
   assign hit             = hit_q;
   assign body_clear      = clr_q;
   assign length          = len_q;
   assign invuln          = (st_q == ST_COOLDOWN);
   assign dead            = (st_q == ST_DEAD);

endmodule

// File: tb/tb_dragon_segment_scheduler.sv
// Directed bench for dragon_segment_scheduler: stepping, heal/hit resolution, cooldown,
// DEAD/restart and asynchronous reset, with hand-computed expected values.
module tb_dragon_segment_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       heal_req;
   logic       hit_req;
   logic       restart;
   logic [5:0] movementCounter;
   logic       move_tick;
   logic       heal;
   logic       hit;
   logic       body_clear;
   logic [2:0] length;
   logic       invuln;
   logic       dead;

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned mc_exp = 0;
   bit          frozen = 1'b0;

   dragon_segment_scheduler #(
      .MOVE_PERIOD     (10),
      .COOLDOWN_FRAMES (60),
      .MAX_LEN         (7)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .vsync           (vsync),
      .heal_req        (heal_req),
      .hit_req         (hit_req),
      .restart         (restart),
      .movementCounter (movementCounter),
      .move_tick       (move_tick),
      .heal            (heal),
      .hit             (hit),
      .body_clear      (body_clear),
      .length          (length),
      .invuln          (invuln),
      .dead            (dead)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One frame: a low sample, then a high sample that produces the tick.
   task automatic frame();
      vsync = 1'b0;
      @(posedge clk); #1;
      vsync = 1'b1;
      @(posedge clk); #1;
      if (!frozen) mc_exp = (mc_exp == 10) ? 0 : mc_exp + 1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic to_step();
      while (mc_exp != 10) frame();
      frame();
   endtask

   task automatic req(input bit h, input bit x);
      heal_req = h;
      hit_req  = x;
      @(posedge clk); #1;
      heal_req = 1'b0;
      hit_req  = 1'b0;
   endtask

   initial begin
      reset = 1'b0; vsync = 1'b0; heal_req = 1'b0; hit_req = 1'b0; restart = 1'b0;
      @(posedge clk); #1;
      chk("rst_mc", movementCounter, 0);
      chk("rst_len", length, 1);
      chk("rst_pulses", {move_tick, heal, hit, body_clear}, 0);
      chk("rst_flags", {invuln, dead}, 0);

      // vsync already high at release: tick on the first clock.
      vsync = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      mc_exp = 1;
      chk("first_tick_mc", movementCounter, 1);

      for (int i = 2; i <= 10; i++) begin
         frame();
         chk("count_mc", movementCounter, i);
         chk("count_no_tick", move_tick, 0);
      end
      frame();
      chk("wrap_mc", movementCounter, 0);
      chk("step_tick", move_tick, 1);
      chk("step_no_action", {heal, hit}, 0);
      @(posedge clk); #1;
      chk("tick_one_cycle", move_tick, 0);

      // Grow: three requests, one step.
      req(1, 0); req(1, 0); req(1, 0);
      to_step();
      chk("heal_pulse", {move_tick, heal, hit}, 3'b110);
      chk("heal_len", length, 2);
      chk("heal_pend2", dut.heal_pend_q, 2);

      // Pending heal cancels a later hit.
      req(0, 1);
      to_step();
      chk("cancel_pulse", {move_tick, heal, hit}, 3'b100);
      chk("cancel_len", length, 2);
      to_step();
      chk("heal2_len", length, 3);
      chk("heal2_pend", dut.heal_pend_q, 0);

      // Simultaneous heal and hit request.
      req(1, 1);
      to_step();
      chk("same_pulse", {move_tick, heal, hit}, 3'b100);
      chk("same_len", length, 3);
      chk("same_pends", {dut.heal_pend_q, dut.hit_pend_q}, 0);

      // Hit with cooldown; hit at cooldown frame 30 is ignored.
      req(0, 1);
      to_step();
      chk("hit_pulse", {move_tick, heal, hit}, 3'b101);
      chk("hit_len", length, 2);
      chk("hit_invuln", invuln, 1);
      frames(30);
      req(0, 1);
      chk("cd_hit_ignored", dut.hit_pend_q, 0);
      frames(29);
      chk("cd_59_invuln", invuln, 1);
      frame();
      chk("cd_60_done", invuln, 0);
      chk("cd_mc", movementCounter, 5);
      chk("cd_len", length, 2);

      // Down to one segment, then a lethal hit.
      req(0, 1);
      to_step();
      chk("hit2_len", length, 1);
      frames(60);
      chk("cd2_done", invuln, 0);
      req(0, 1);
      to_step();
      chk("die_flags", {dead, invuln}, 2'b10);
      chk("die_no_hit", {move_tick, heal, hit}, 3'b100);
      chk("die_len", length, 1);
      frozen = 1'b1;
      frames(3);
      chk("dead_frozen_mc", movementCounter, 0);
      chk("dead_no_tick", move_tick, 0);
      req(1, 1);
      chk("dead_req_ignored", {dut.heal_pend_q, dut.hit_pend_q}, 0);
      restart = 1'b1;
      @(posedge clk); #1;
      restart = 1'b0;
      frozen = 1'b0;
      mc_exp = 0;
      chk("restart_clear", body_clear, 1);
      chk("restart_state", {dead, invuln, length}, 5'b00001);
      @(posedge clk); #1;
      chk("clear_one_cycle", body_clear, 0);

      // Saturation and growth to MAX_LEN.
      req(1, 0); req(1, 0); req(1, 0); req(1, 0);
      chk("heal_sat", dut.heal_pend_q, 3);
      to_step(); to_step(); to_step();
      chk("len4", length, 4);
      req(1, 0); req(1, 0); req(1, 0);
      to_step(); to_step(); to_step();
      chk("len7", length, 7);
      req(1, 0);
      to_step();
      chk("max_drop_pulse", {move_tick, heal, hit}, 3'b100);
      chk("max_len", length, 7);
      chk("max_pend", dut.heal_pend_q, 0);

      // Asynchronous reset in the middle of cooldown.
      req(0, 1);
      to_step();
      chk("hit7_len", length, 6);
      frames(5);
      chk("pre_rst_invuln", invuln, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_mc", movementCounter, 0);
      chk("async_len", length, 1);
      chk("async_flags", {invuln, dead}, 0);
      chk("async_pulses", {move_tick, heal, hit, body_clear}, 0);
      #3;
      @(posedge clk); #1;
      reset = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
